// File: rtl/random_perm3_unmap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : random_perm3_unmap
// Description : Two-stage valid/ready pipeline. It decodes a 7-bit random code
//               into a 3-element permutation index and undoes that permutation
//               on a frame of three 2-bit elements. It also counts output
//               frames.
// Revision    : 1.0 - initial release
// ============================================================================
module random_perm3_unmap #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_y,
  input  logic [6:0]       in_random,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_x,
  output logic [2:0]       out_perm,
  output logic [CNT_W-1:0] frame_count
);

  // First code value of each permutation band (band 0 starts at 0)
  localparam logic [6:0] c_BAND1 = 7'd21;
  localparam logic [6:0] c_BAND2 = 7'd42;
  localparam logic [6:0] c_BAND3 = 7'd64;
  localparam logic [6:0] c_BAND4 = 7'd85;
  localparam logic [6:0] c_BAND5 = 7'd106;

  logic             r_s1_valid;
  logic [5:0]       r_s1_y;
  logic [2:0]       r_s1_perm;
  logic             r_s2_valid;
  logic [5:0]       r_s2_x;
  logic [2:0]       r_s2_perm;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_perm;
  logic [5:0] w_x;
  logic       w_s2_adv;
  logic       w_s1_open;

  // Stage 2 can take a new frame when it is empty or is being drained.
  // Stage 1 advances whenever stage 2 does. Stage 1 accepts input when it is
  // empty or is advancing. in_ready therefore depends only on registered
  // state and out_ready. in_ready is held low during reset.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_open = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_open && !rst;

  // Map the random code onto its permutation band
  always_comb begin
    w_perm = 3'd5;
    if (in_random < c_BAND1)      w_perm = 3'd0;
    else if (in_random < c_BAND2) w_perm = 3'd1;
    else if (in_random < c_BAND3) w_perm = 3'd2;
    else if (in_random < c_BAND4) w_perm = 3'd3;
    else if (in_random < c_BAND5) w_perm = 3'd4;
  end

  // Undo the permutation on the stage-1 frame. Each element X is taken from
  // the element Y position selected by the index. Indices 6 and 7 cannot
  // occur, so they fall back to the identity order.
  always_comb begin
    w_x = r_s1_y;
    case (r_s1_perm)
      3'd1:    w_x = {r_s1_y[3:2], r_s1_y[5:4], r_s1_y[1:0]};
      3'd2:    w_x = {r_s1_y[5:4], r_s1_y[1:0], r_s1_y[3:2]};
      3'd3:    w_x = {r_s1_y[1:0], r_s1_y[5:4], r_s1_y[3:2]};
      3'd4:    w_x = {r_s1_y[3:2], r_s1_y[1:0], r_s1_y[5:4]};
      3'd5:    w_x = {r_s1_y[1:0], r_s1_y[3:2], r_s1_y[5:4]};
      default: w_x = r_s1_y;
    endcase
  end

  // Stage 1: capture the incoming frame together with its decoded index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s1_perm  <= '0;
    end else if (w_s1_open) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_y    <= in_y;
        r_s1_perm <= w_perm;
      end
    end
  end

  // Stage 2: capture the restored frame. Hold it while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_x     <= '0;
      r_s2_perm  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_x    <= w_x;
        r_s2_perm <= r_s1_perm;
      end
    end
  end

  // Count completed output transfers, wrapping naturally at the counter width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_x       = r_s2_x;
  assign out_perm    = r_s2_perm;
  assign frame_count = r_cnt;

endmodule
`default_nettype wire
